// File: rtl/xillybus_bridge_pkg.sv
// Shared register map, bit positions and helpers for the Xillybus ap_fifo bridge.
package xillybus_bridge_pkg;

    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] REG_DCNT0  = 5'd4;
    localparam logic [4:0] REG_UCNT0  = 5'd8;
    localparam logic [4:0] REG_ID     = 5'd12;

    localparam int CTRL_EOF    = 0;
    localparam int CTRL_DFLUSH = 1;
    localparam int CTRL_UFLUSH = 2;

    localparam int ST_OVF    = 0;
    localparam int ST_UEMPTY = 1;
    localparam int ST_DEMPTY = 2;
    localparam int ST_DFULL  = 3;

    localparam logic [7:0] ID_VALUE = 8'hA5;

    // Little-endian byte lane of a 32-bit counter snapshot.
    function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[7:0];
            2'd1:    return v[15:8];
            2'd2:    return v[23:16];
            default: return v[31:24];
        endcase
    endfunction

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with either a first-word-fall-through head register or a
// registered read port; count covers every word held, including the head register.
module bridge_sync_fifo #(
    parameter int W          = 128,
    parameter int DEPTH_LOG2 = 9,
    parameter bit FWFT       = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [W-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr, rptr, count;
    logic                head_vld;
    logic                push_ok, pop_ok, ram_rd, ram_empty;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign ram_empty = (wptr == rptr);
    assign push_ok   = push & ~full;
    assign pop_ok    = FWFT ? (pop & head_vld) : (pop & ~empty);
    // FWFT refills the head register whenever it is vacant or being consumed.
    assign ram_rd    = FWFT ? (~ram_empty & (~head_vld | pop_ok)) : pop_ok;
    assign valid     = head_vld;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr[DEPTH_LOG2-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            head_vld <= 1'b0;
            dout     <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (ram_rd) begin
                dout <= mem[rptr[DEPTH_LOG2-1:0]];
                rptr <= rptr + 1'b1;
            end
            count <= count + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop_ok};
            if (FWFT) begin
                if (ram_rd)
                    head_vld <= 1'b1;
                else if (pop_ok)
                    head_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/xillybus_apfifo_bridge.sv
// Bridges Xillybus 128-bit streams to HLS ap_fifo ports, with a small
// control/status/counter register bank on the 8-bit mem port.
module xillybus_apfifo_bridge
    import xillybus_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DATA_W     = 128
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              user_w_write_128_wren,
    input  logic [DATA_W-1:0] user_w_write_128_data,
    input  logic              user_w_write_128_open,
    output logic              user_w_write_128_full,
    input  logic              user_r_read_128_rden,
    input  logic              user_r_read_128_open,
    output logic [DATA_W-1:0] user_r_read_128_data,
    output logic              user_r_read_128_empty,
    output logic              user_r_read_128_eof,
    input  logic              user_w_mem_8_wren,
    input  logic [7:0]        user_w_mem_8_data,
    input  logic              user_w_mem_8_open,
    output logic              user_w_mem_8_full,
    input  logic              user_r_mem_8_rden,
    input  logic              user_r_mem_8_open,
    output logic [7:0]        user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    input  logic [4:0]        user_mem_8_addr,
    input  logic              user_mem_8_addr_update,
    output logic [DATA_W-1:0] k_in_dout,
    output logic              k_in_empty_n,
    input  logic              k_in_read,
    input  logic [DATA_W-1:0] k_out_din,
    input  logic              k_out_write,
    output logic              k_out_full_n
);
    logic        dn_flush, up_flush, dn_vld, dn_empty, dn_full, up_empty, up_full;
    logic        up_head_unused, unused_ok;
    logic        reg_wr, ovf, eof_req, open_q;
    logic [31:0] dcnt, ucnt, dcnt_shadow, ucnt_shadow;
    logic [7:0]  rd_mux;

    assign reg_wr   = user_w_mem_8_wren;
    assign dn_flush = reg_wr & (user_mem_8_addr == REG_CTRL) & user_w_mem_8_data[CTRL_DFLUSH];
    assign up_flush = reg_wr & (user_mem_8_addr == REG_CTRL) & user_w_mem_8_data[CTRL_UFLUSH];

    bridge_sync_fifo #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .FWFT(1'b1)) u_down (
        .clk(bus_clk), .rst_n(bus_rst_n), .flush(dn_flush),
        .push(user_w_write_128_wren), .din(user_w_write_128_data),
        .pop(k_in_read), .dout(k_in_dout), .valid(dn_vld),
        .empty(dn_empty), .full(dn_full)
    );

    bridge_sync_fifo #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .FWFT(1'b0)) u_up (
        .clk(bus_clk), .rst_n(bus_rst_n), .flush(up_flush),
        .push(k_out_write), .din(k_out_din),
        .pop(user_r_read_128_rden), .dout(user_r_read_128_data), .valid(up_head_unused),
        .empty(up_empty), .full(up_full)
    );

    // Flow-control flags are forced to their safe values while reset is held.
    assign user_w_write_128_full = ~bus_rst_n | dn_full;
    assign user_r_read_128_empty = ~bus_rst_n | up_empty;
    assign k_in_empty_n          = bus_rst_n & dn_vld;
    assign k_out_full_n          = bus_rst_n & ~up_full;
    assign user_r_read_128_eof   = bus_rst_n & eof_req & up_empty;

    assign user_w_mem_8_full  = 1'b0;
    assign user_r_mem_8_empty = 1'b0;
    assign user_r_mem_8_eof   = 1'b0;

    assign unused_ok = &{1'b0, user_w_write_128_open, user_w_mem_8_open, user_r_mem_8_open,
                         user_w_mem_8_data[7:3], up_head_unused};

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            ovf     <= 1'b0;
            eof_req <= 1'b0;
            open_q  <= 1'b0;
        end else begin
            open_q <= user_r_read_128_open;
            if (user_w_write_128_wren & user_w_write_128_full)
                ovf <= 1'b1;
            else if (reg_wr & (user_mem_8_addr == REG_STATUS) & user_w_mem_8_data[ST_OVF])
                ovf <= 1'b0;
            // Closing the read stream always cancels a pending EOF request.
            if (open_q & ~user_r_read_128_open)
                eof_req <= 1'b0;
            else if (reg_wr & (user_mem_8_addr == REG_CTRL))
                eof_req <= user_w_mem_8_data[CTRL_EOF];
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            dcnt        <= '0;
            ucnt        <= '0;
            dcnt_shadow <= '0;
            ucnt_shadow <= '0;
        end else begin
            if (dn_flush)
                dcnt <= '0;
            else if (user_w_write_128_wren & ~user_w_write_128_full)
                dcnt <= dcnt + 32'd1;
            if (up_flush)
                ucnt <= '0;
            else if (k_out_write & k_out_full_n)
                ucnt <= ucnt + 32'd1;
            if (user_mem_8_addr_update & (user_mem_8_addr == REG_DCNT0))
                dcnt_shadow <= dcnt;
            if (user_mem_8_addr_update & (user_mem_8_addr == REG_UCNT0))
                ucnt_shadow <= ucnt;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (user_mem_8_addr == REG_CTRL) begin
            rd_mux[CTRL_EOF] = eof_req;
        end else if (user_mem_8_addr == REG_STATUS) begin
            rd_mux[ST_OVF]    = ovf;
            rd_mux[ST_UEMPTY] = up_empty;
            rd_mux[ST_DEMPTY] = dn_empty;
            rd_mux[ST_DFULL]  = dn_full;
        end else if (user_mem_8_addr[4:2] == REG_DCNT0[4:2]) begin
            rd_mux = byte_sel(dcnt_shadow, user_mem_8_addr[1:0]);
        end else if (user_mem_8_addr[4:2] == REG_UCNT0[4:2]) begin
            rd_mux = byte_sel(ucnt_shadow, user_mem_8_addr[1:0]);
        end else if (user_mem_8_addr == REG_ID) begin
            rd_mux = ID_VALUE;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n)
            user_r_mem_8_data <= '0;
        else if (user_r_mem_8_rden)
            user_r_mem_8_data <= rd_mux;
    end

endmodule
